// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the bundle of latch stall/flush controls plus the PC enable.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_HOLD = 2'd1,
        DWAIT   = 2'd2,
        HALTED  = 2'd3
    } hzu_state_t;

    typedef struct packed {
        logic stall_ifid;
        logic stall_idex;
        logic stall_xmem;
        logic stall_wb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_xmem;
        logic pc_en;
    } hzu_ctrl_t;

    localparam hzu_ctrl_t CTRL_IDLE       = '0;
    localparam int        MAX_FLUSH_DEPTH = 3;
    localparam int        MAX_LU_CYCLES   = 3;

    // Freeze IF/ID and squash the instruction entering EX; PC holds.
    function automatic hzu_ctrl_t ctrl_bubble();
        hzu_ctrl_t c;
        c            = CTRL_IDLE;
        c.stall_ifid = 1'b1;
        c.flush_idex = 1'b1;
        return c;
    endfunction

    // Freeze every latch while data memory is busy.
    function automatic hzu_ctrl_t ctrl_freeze_all();
        hzu_ctrl_t c;
        c            = CTRL_IDLE;
        c.stall_ifid = 1'b1;
        c.stall_idex = 1'b1;
        c.stall_xmem = 1'b1;
        c.stall_wb   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle. The datapath side (master)
// supplies decode/execute/memory status; the controller (slave) returns latch controls.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic [REG_W-1:0] idex_rd;
    logic             idex_memread;
    logic             branch;
    logic             alu_zf;
    logic             jump;
    logic             ihit;
    logic             dmem_req;
    logic             dhit;
    logic             halt;

    logic             stall_ifid;
    logic             stall_idex;
    logic             stall_xmem;
    logic             stall_wb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_xmem;
    logic             pc_en;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_rs, ifid_rt, idex_rd, idex_memread,
        output branch, alu_zf, jump, ihit, dmem_req, dhit, halt,
        input  stall_ifid, stall_idex, stall_xmem, stall_wb,
        input  flush_ifid, flush_idex, flush_xmem, pc_en, stall_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rd, idex_memread,
        input  branch, alu_zf, jump, ihit, dmem_req, dhit, halt,
        output stall_ifid, stall_idex, stall_xmem, stall_wb,
        output flush_ifid, flush_idex, flush_xmem, pc_en, stall_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for performance counters
// where wrap-around would make long-run statistics misleading.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, branch/jump flush,
// instruction/data memory wait handling, sticky halt and a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 1,
    parameter int LU_CYCLES   = 1,
    parameter int CNT_W       = 32
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  bus
);

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    generate
        if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > MAX_FLUSH_DEPTH) begin : g_bad_flush_depth
            $error("hazard_ctrl: FLUSH_DEPTH must be within 1..3");
        end
        if (LU_CYCLES < 1 || LU_CYCLES > MAX_LU_CYCLES) begin : g_bad_lu_cycles
            $error("hazard_ctrl: LU_CYCLES must be within 1..3");
        end
    endgenerate

    hzu_state_t state_reg;
    hzu_state_t state_next;
    hzu_state_t eff_state;
    logic [1:0] lu_left_reg;
    logic [1:0] lu_left_next;
    hzu_ctrl_t  ctrl;
    logic       cnt_inc;

    logic [MAX_FLUSH_DEPTH-1:0] flush_mask;

    // Bit gi set when latch gi (0=IF/ID, 1=ID/EX, 2=EX/MEM) is squashed on redirect.
    generate
        for (genvar gi = 0; gi < MAX_FLUSH_DEPTH; gi++) begin : g_flush_mask
            assign flush_mask[gi] = (gi < FLUSH_DEPTH);
        end
    endgenerate

    logic taken;
    logic load_use;
    logic dmiss;

    assign taken    = (bus.branch && bus.alu_zf) || bus.jump;
    assign load_use = bus.idex_memread && (bus.idex_rd != ZERO_REG) &&
                      ((bus.idex_rd == bus.ifid_rs) || (bus.idex_rd == bus.ifid_rt));
    assign dmiss    = bus.dmem_req && !bus.dhit;

    // Once the data miss clears, DWAIT behaves like whatever it interrupted:
    // a frozen load-use hold if bubbles remain, otherwise normal running.
    always_comb begin
        eff_state = state_reg;
        if (state_reg == DWAIT) begin
            eff_state = (lu_left_reg != 2'd0) ? LU_HOLD : RUN;
        end
    end

    always_comb begin
        ctrl         = CTRL_IDLE;
        state_next   = eff_state;
        lu_left_next = lu_left_reg;
        cnt_inc      = 1'b0;

        if (RST) begin
            ctrl         = CTRL_IDLE;
            state_next   = RUN;
            lu_left_next = 2'd0;
        end else if (bus.halt || (state_reg == HALTED)) begin
            ctrl       = ctrl_bubble();
            state_next = HALTED;
        end else begin
            if (dmiss) begin
                ctrl       = ctrl_freeze_all();
                state_next = DWAIT;
            end else if (taken) begin
                // The dependent instruction is being flushed, so any load-use
                // stall (pending or new) is moot.
                ctrl.flush_ifid = flush_mask[0];
                ctrl.flush_idex = flush_mask[1];
                ctrl.flush_xmem = flush_mask[2];
                ctrl.pc_en      = 1'b1;
                state_next      = RUN;
                lu_left_next    = 2'd0;
            end else if (eff_state == LU_HOLD) begin
                ctrl         = ctrl_bubble();
                lu_left_next = lu_left_reg - 2'd1;
                state_next   = (lu_left_reg == 2'd1) ? RUN : LU_HOLD;
            end else if (load_use) begin
                ctrl = ctrl_bubble();
                if (LU_CYCLES > 1) begin
                    state_next   = LU_HOLD;
                    lu_left_next = 2'(LU_CYCLES - 1);
                end
            end else if (!bus.ihit) begin
                ctrl.flush_ifid = 1'b1;
            end else begin
                ctrl.pc_en = 1'b1;
            end
            cnt_inc = !ctrl.pc_en;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= RUN;
            lu_left_reg <= 2'd0;
        end else begin
            state_reg   <= state_next;
            lu_left_reg <= lu_left_next;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (cnt_inc),
        .count (bus.stall_cnt)
    );

    assign bus.stall_ifid = ctrl.stall_ifid;
    assign bus.stall_idex = ctrl.stall_idex;
    assign bus.stall_xmem = ctrl.stall_xmem;
    assign bus.stall_wb   = ctrl.stall_wb;
    assign bus.flush_ifid = ctrl.flush_ifid;
    assign bus.flush_idex = ctrl.flush_idex;
    assign bus.flush_xmem = ctrl.flush_xmem;
    assign bus.pc_en      = ctrl.pc_en;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two differently parameterised instances share one
// stimulus stream; table vectors, hand-built multi-cycle sequences, random run.
module tb_hazard_ctrl;

    localparam int FD_A = 3;
    localparam int LU_A = 2;
    localparam int CW_A = 4;
    localparam int FD_B = 1;
    localparam int LU_B = 3;
    localparam int CW_B = 32;

    // Output vector layout: {stall_ifid, stall_idex, stall_xmem, stall_wb,
    //                        flush_ifid, flush_idex, flush_xmem, pc_en}
    localparam logic [7:0] O_RUN    = 8'h01;
    localparam logic [7:0] O_IMISS  = 8'h08;
    localparam logic [7:0] O_BUBBLE = 8'h84;
    localparam logic [7:0] O_FREEZE = 8'hF0;
    localparam logic [7:0] O_FL3    = 8'h0F;
    localparam logic [7:0] O_FL1    = 8'h09;
    localparam logic [7:0] O_ZERO   = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, rd;
    logic       memread, branch, alu_zf, jump, ihit, dmem_req, dhit, halt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(CW_A)) bus_a ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(CW_B)) bus_b ();

    assign bus_a.ifid_rs      = rs;
    assign bus_a.ifid_rt      = rt;
    assign bus_a.idex_rd      = rd;
    assign bus_a.idex_memread = memread;
    assign bus_a.branch       = branch;
    assign bus_a.alu_zf       = alu_zf;
    assign bus_a.jump         = jump;
    assign bus_a.ihit         = ihit;
    assign bus_a.dmem_req     = dmem_req;
    assign bus_a.dhit         = dhit;
    assign bus_a.halt         = halt;

    assign bus_b.ifid_rs      = rs;
    assign bus_b.ifid_rt      = rt;
    assign bus_b.idex_rd      = rd;
    assign bus_b.idex_memread = memread;
    assign bus_b.branch       = branch;
    assign bus_b.alu_zf       = alu_zf;
    assign bus_b.jump         = jump;
    assign bus_b.ihit         = ihit;
    assign bus_b.dmem_req     = dmem_req;
    assign bus_b.dhit         = dhit;
    assign bus_b.halt         = halt;

    hazard_ctrl #(
        .REG_W(5), .FLUSH_DEPTH(FD_A), .LU_CYCLES(LU_A), .CNT_W(CW_A)
    ) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a.slave)
    );

    hazard_ctrl #(
        .REG_W(5), .FLUSH_DEPTH(FD_B), .LU_CYCLES(LU_B), .CNT_W(CW_B)
    ) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b.slave)
    );

    logic [7:0]  act_v [2];
    logic [31:0] act_c [2];

    assign act_v[0] = {bus_a.stall_ifid, bus_a.stall_idex, bus_a.stall_xmem, bus_a.stall_wb,
                       bus_a.flush_ifid, bus_a.flush_idex, bus_a.flush_xmem, bus_a.pc_en};
    assign act_v[1] = {bus_b.stall_ifid, bus_b.stall_idex, bus_b.stall_xmem, bus_b.stall_wb,
                       bus_b.flush_ifid, bus_b.flush_idex, bus_b.flush_xmem, bus_b.pc_en};
    assign act_c[0] = {28'd0, bus_a.stall_cnt};
    assign act_c[1] = bus_b.stall_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: halted flag, count of load-use bubbles still owed, counter.
    int     m_halted [2];
    int     m_left   [2];
    longint m_cnt    [2];

    task automatic model_step(input int d, input bit cmp);
        int         fd, luc, cw;
        longint     cmax;
        bit         tk, lu, miss;
        logic [7:0] e;
        fd   = (d == 0) ? FD_A : FD_B;
        luc  = (d == 0) ? LU_A : LU_B;
        cw   = (d == 0) ? CW_A : CW_B;
        cmax = (longint'(1) << cw) - 1;
        tk   = (branch && alu_zf) || jump;
        lu   = memread && (rd != 5'd0) && ((rd == rs) || (rd == rt));
        miss = dmem_req && !dhit;

        if (rst)                           e = O_ZERO;
        else if (halt || m_halted[d] != 0) e = O_BUBBLE;
        else if (miss)                     e = O_FREEZE;
        else if (tk)                       e = {4'b0000, 1'b1, (fd >= 2) ? 1'b1 : 1'b0,
                                                (fd == 3) ? 1'b1 : 1'b0, 1'b1};
        else if (m_left[d] > 0)            e = O_BUBBLE;
        else if (lu)                       e = O_BUBBLE;
        else if (!ihit)                    e = O_IMISS;
        else                               e = O_RUN;

        if (cmp) begin
            check($sformatf("rand_out_dut%0d", d), {24'd0, act_v[d]}, {24'd0, e});
            check($sformatf("rand_cnt_dut%0d", d), act_c[d], 32'(m_cnt[d]));
        end

        if (rst) begin
            m_halted[d] = 0;
            m_left[d]   = 0;
            m_cnt[d]    = 0;
        end else if (halt || m_halted[d] != 0) begin
            m_halted[d] = 1;
        end else begin
            if (!e[0] && m_cnt[d] < cmax) m_cnt[d]++;
            if (miss)               ;
            else if (tk)            m_left[d] = 0;
            else if (m_left[d] > 0) m_left[d]--;
            else if (lu)            m_left[d] = luc - 1;
        end
    endtask

    // Called at the negedge once inputs are stable; advances through the next posedge.
    task automatic tick(input bit cmp);
        model_step(0, cmp);
        model_step(1, cmp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs = 5'd0; rt = 5'd0; rd = 5'd0;
        memread = 1'b0; branch = 1'b0; alu_zf = 1'b0; jump = 1'b0;
        ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic chk2(input string name, input logic [7:0] ea, input logic [7:0] eb);
        check({name, "_a"}, {24'd0, act_v[0]}, {24'd0, ea});
        check({name, "_b"}, {24'd0, act_v[1]}, {24'd0, eb});
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, rd;
        logic       memread, branch, alu_zf, jump, ihit, dmem_req, dhit, halt;
        logic [7:0] exp_a, exp_b;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] dd, input logic [7:0] ins,
                                input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.rst = r; v.rs = s; v.rt = t; v.rd = dd;
        {v.memread, v.branch, v.alu_zf, v.jump, v.ihit, v.dmem_req, v.dhit, v.halt} = ins;
        v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        // ins bits: memread branch alu_zf jump ihit dmem_req dhit halt
        vecs[0]  = mk(0, 0, 0, 0, 8'b0000_1000, O_RUN,    O_RUN);
        vecs[1]  = mk(0, 0, 0, 0, 8'b0000_0000, O_IMISS,  O_IMISS);
        vecs[2]  = mk(0, 3, 0, 3, 8'b1000_1000, O_BUBBLE, O_BUBBLE);
        vecs[3]  = mk(0, 1, 0, 0, 8'b1000_1000, O_RUN,    O_RUN);
        vecs[4]  = mk(0, 2, 7, 7, 8'b1000_1000, O_BUBBLE, O_BUBBLE);
        vecs[5]  = mk(0, 3, 0, 3, 8'b0000_1000, O_RUN,    O_RUN);
        vecs[6]  = mk(0, 0, 0, 0, 8'b0100_1000, O_RUN,    O_RUN);
        vecs[7]  = mk(0, 3, 0, 3, 8'b1110_0000, O_FL3,    O_FL1);
        vecs[8]  = mk(0, 0, 0, 0, 8'b0001_1000, O_FL3,    O_FL1);
        vecs[9]  = mk(0, 0, 0, 0, 8'b0000_1100, O_FREEZE, O_FREEZE);
        vecs[10] = mk(0, 0, 0, 0, 8'b0111_1100, O_FREEZE, O_FREEZE);
        vecs[11] = mk(0, 0, 0, 0, 8'b0000_1110, O_RUN,    O_RUN);
        vecs[12] = mk(0, 0, 0, 0, 8'b0000_1001, O_BUBBLE, O_BUBBLE);
        vecs[13] = mk(0, 0, 0, 0, 8'b0000_1101, O_BUBBLE, O_BUBBLE);
        vecs[14] = mk(1, 3, 3, 3, 8'b1001_0100, O_ZERO,   O_ZERO);

        for (int d = 0; d < 2; d++) begin
            m_halted[d] = 0; m_left[d] = 0; m_cnt[d] = 0;
        end
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk2("reset_out", O_RUN, O_RUN);
        check("reset_cnt_a", act_c[0], 32'd0);
        check("reset_cnt_b", act_c[1], 32'd0);
        tick(1'b0);

        // Single-cycle table vectors, each from a freshly reset controller
        for (int i = 0; i < 15; i++) begin
            do_reset();
            rst = vecs[i].rst; rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd;
            memread = vecs[i].memread; branch = vecs[i].branch; alu_zf = vecs[i].alu_zf;
            jump = vecs[i].jump; ihit = vecs[i].ihit; dmem_req = vecs[i].dmem_req;
            dhit = vecs[i].dhit; halt = vecs[i].halt;
            @(negedge clk);
            chk2($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
            $display("vector %0d: a=%b b=%b", i, act_v[0], act_v[1]);
            tick(1'b0);
        end

        // Load-use stall length per instance
        do_reset();
        memread = 1'b1; rd = 5'd3; rs = 5'd3;
        @(negedge clk); chk2("lu_c0", O_BUBBLE, O_BUBBLE); tick(1'b0);
        memread = 1'b0;
        @(negedge clk); chk2("lu_c1", O_BUBBLE, O_BUBBLE); tick(1'b0);
        @(negedge clk); chk2("lu_c2", O_RUN, O_BUBBLE);
        check("lu_cnt_a", act_c[0], 32'd2); tick(1'b0);
        @(negedge clk); chk2("lu_c3", O_RUN, O_RUN);
        check("lu_cnt_b", act_c[1], 32'd3); tick(1'b0);
        $display("sequence load-use done");

        // Data miss in the middle of a load-use hold
        do_reset();
        memread = 1'b1; rd = 5'd3; rs = 5'd3;
        @(negedge clk); chk2("dm_c0", O_BUBBLE, O_BUBBLE); tick(1'b0);
        memread = 1'b0;
        @(negedge clk); chk2("dm_c1", O_BUBBLE, O_BUBBLE); tick(1'b0);
        dmem_req = 1'b1; dhit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk2($sformatf("dm_miss%0d", k), O_FREEZE, O_FREEZE); tick(1'b0);
        end
        dmem_req = 1'b0;
        @(negedge clk); chk2("dm_c6", O_RUN, O_BUBBLE); tick(1'b0);
        @(negedge clk); chk2("dm_c7", O_RUN, O_RUN);
        check("dm_cnt_a", act_c[0], 32'd6);
        check("dm_cnt_b", act_c[1], 32'd7);
        tick(1'b0);
        $display("sequence dmiss-in-lu done");

        // Sticky halt, then reset exit
        do_reset();
        ihit = 1'b0;
        repeat (2) begin @(negedge clk); tick(1'b0); end
        ihit = 1'b1; halt = 1'b1;
        @(negedge clk); chk2("halt_pulse", O_BUBBLE, O_BUBBLE); tick(1'b0);
        halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("halted_out%0d", k), {24'd0, act_v[0]}, {24'd0, O_BUBBLE});
            check($sformatf("halted_cnt%0d", k), act_c[1], 32'd2);
            tick(1'b0);
        end
        rst = 1'b1;
        @(negedge clk); chk2("halt_rst", O_ZERO, O_ZERO); tick(1'b0);
        rst = 1'b0;
        @(negedge clk); chk2("halt_exit", O_RUN, O_RUN);
        check("halt_exit_cnt_a", act_c[0], 32'd0);
        tick(1'b0);
        $display("sequence halt done");

        // Counter saturation on the 4-bit instance
        do_reset();
        ihit = 1'b0;
        repeat (20) begin @(negedge clk); tick(1'b0); end
        @(negedge clk);
        check("sat_cnt_a", act_c[0], 32'd15);
        check("sat_cnt_b", act_c[1], 32'd20);
        tick(1'b0);
        $display("sequence saturation done");

        // Randomised run against the reference model
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            for (int k = 0; k < 250; k++) begin
                rst      = ($urandom_range(0, 99) == 0);
                halt     = ($urandom_range(0, 299) == 0);
                rs       = 5'($urandom_range(0, 3));
                rt       = 5'($urandom_range(0, 3));
                rd       = 5'($urandom_range(0, 3));
                memread  = ($urandom_range(0, 2) == 0);
                branch   = ($urandom_range(0, 3) == 0);
                alu_zf   = ($urandom_range(0, 1) == 0);
                jump     = ($urandom_range(0, 11) == 0);
                ihit     = ($urandom_range(0, 4) != 0);
                dmem_req = ($urandom_range(0, 3) == 0);
                dhit     = ($urandom_range(0, 1) == 0);
                @(negedge clk);
                tick(1'b1);
            end
            $display("random block %0d: %0d checks so far", blk, n_checks);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
